// File: rtl/div_check_multiplier.sv
// div_check_multiplier: sequential shift-add unit that rebuilds a dividend
// from a division result (Q*D + R) and flags out-of-range remainders.
// Shares the switch/go front end of the restoring divider; one operation
// takes IDLE, WAIT, 4 x ITER, ADDREM, DONE.
module div_check_multiplier (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] data_in,
  input  logic [3:0] rem_in,
  output logic [7:0] data_result,
  output logic       err,
  output logic       done,
  output logic       busy
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 8;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ITER   = 3'd2,
    S_ADDREM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state;
  logic [RES_W-1:0]   mcand;
  logic [OP_W-1:0]    mplier;
  logic [RES_W-1:0]   acc;
  logic [OP_W-1:0]    rem_q;
  logic [OP_W-1:0]    d_q;
  logic [CNT_W-1:0]   count;

  // Status flags are decoded straight from the state register, so they
  // change only on clock edges.
  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

  // Control FSM and datapath: operand capture, shift-add iterations,
  // remainder add and range check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      data_result <= '0;
      err         <= 1'b0;
      acc         <= '0;
      count       <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem_q       <= '0;
      d_q         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Operands track the switches until go is seen; the edge that
          // samples go==1 is the one that captures them.
          mcand  <= {{(RES_W-OP_W){1'b0}}, data_in[7:4]};
          mplier <= data_in[3:0];
          d_q    <= data_in[3:0];
          rem_q  <= rem_in;
          acc    <= '0;
          count  <= '0;
          if (go) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Start only once go is released so a held key runs one op.
          if (!go) begin
            state <= S_ITER;
          end
        end

        S_ITER: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(3)) begin
            state <= S_ADDREM;
          end
        end

        S_ADDREM: begin
          // Result is written even for D==0 so the display shows R.
          data_result <= acc + {{(RES_W-OP_W){1'b0}}, rem_q};
          err         <= (d_q == '0) | (rem_q >= d_q);
          state       <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_check_multiplier.sv
// Testbench for div_check_multiplier: directed and random operations
// checked against an arithmetic reference (Q*D+R, err when R>=D or D==0).
module tb_div_check_multiplier;

  logic       clk;
  logic       reset;
  logic       go;
  logic [7:0] data_in;
  logic [3:0] rem_in;
  logic [7:0] data_result;
  logic       err;
  logic       done;
  logic       busy;

  int checks;
  int errors;

  div_check_multiplier dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .data_in     (data_in),
    .rem_in      (rem_in),
    .data_result (data_result),
    .err         (err),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit after it, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Reference model: the value the operation must reconstruct.
  function automatic logic [7:0] ref_result(input logic [3:0] q, input logic [3:0] d,
                                            input logic [3:0] r);
    int v;
    v = int'(q) * int'(d) + int'(r);
    return 8'(v);
  endfunction

  function automatic logic ref_err(input logic [3:0] d, input logic [3:0] r);
    return (int'(d) == 0) || (int'(r) >= int'(d));
  endfunction

  // One complete operation: go held for 'hold' edges (inputs scrambled after
  // capture), then done must arrive on the 6th edge after go falls.
  task automatic run_op(input logic [3:0] q, input logic [3:0] d, input logic [3:0] r,
                        input int hold, input string tag);
    int n;
    data_in = {q, d};
    rem_in  = r;
    go      = 1'b1;
    tick();
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 1; i < hold; i++) begin
      data_in = 8'($urandom);
      rem_in  = 4'($urandom);
      tick();
    end
    go      = 1'b0;
    data_in = 8'($urandom);
    rem_in  = 4'($urandom);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'd6);
    chk({tag, "_result"}, 32'(data_result), 32'(ref_result(q, d, r)));
    chk({tag, "_err"}, 32'(err), 32'(ref_err(d, r)));
    tick();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [3:0] rq, rd, rr;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    go      = 1'b0;
    data_in = 8'h00;
    rem_in  = 4'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_result", 32'(data_result), 32'h00);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Directed cases from the plan
    run_op(4'd7, 4'd3, 4'd2, 1, "q7d3r2");
    run_op(4'd15, 4'd15, 4'd14, 1, "max_ok");
    run_op(4'd15, 4'd15, 4'd15, 2, "max_err");
    run_op(4'd9, 4'd0, 4'd5, 1, "d_zero");

    // go held high: stay in WAIT, busy, no done, result unchanged
    data_in = 8'h52;
    rem_in  = 4'd1;
    go      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_nodone", 32'(done), 32'd0);
      chk("hold_result", 32'(data_result), 32'h05);
    end
    go = 1'b0;
    tick();           // samples go==0 in WAIT
    tick();           // first iteration
    data_in = 8'hFF;  // ignored outside IDLE
    rem_in  = 4'hF;
    go      = 1'b1;   // ignored during ITER
    tick();
    go    = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) begin
        ndone++;
        chk("hold_final_result", 32'(data_result), 32'h0B);
        chk("hold_final_err", 32'(err), 32'd0);
      end
    end
    chk("hold_one_done", 32'(ndone), 32'd1);

    // Reset during the 2nd ITER cycle abandons the operation
    data_in = 8'h73;
    rem_in  = 4'd2;
    go      = 1'b1;
    tick();
    go = 1'b0;
    tick();           // go==0 sampled, enter ITER
    tick();           // first iteration edge
    reset = 1'b1;
    tick();           // second iteration edge samples reset
    reset = 1'b0;
    chk("midrst_result", 32'(data_result), 32'h00);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    run_op(4'd4, 4'd4, 4'd3, 1, "after_rst");

    // Random operations with random go pulse lengths
    for (int k = 0; k < 24; k++) begin
      rq = 4'($urandom);
      rd = 4'($urandom);
      rr = (k % 2 == 0 && rd != 4'd0) ? 4'($urandom_range(int'(rd) - 1, 0))
                                      : 4'($urandom);
      run_op(rq, rd, rr, int'($urandom_range(3, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
